uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver: the receive end of the board UART link, paired with the core's transmit side at the same `Clock`/`Baud` settings.
- Frame format: 8N1, LSB first, line idle high.
- Synchronises the `rxd` pin, detects and validates start bits, samples each bit at mid-bit and checks the stop bit.
- Delivers each received byte to the core through a one-entry valid/ready holding register, with framing and overrun flags.

Parameters:
- `Clock`, 50, system clock frequency in MHz.
- `Baud`, 115200, line rate in bit/s.
- `CLKS_PER_BIT`, derived as `(Clock*1000000)/Baud` with integer truncation (434 at defaults). Localparam, not overridable.

Ports:
- `clk`, input, 1, system clock, rising edge.
- `rst`, input, 1, asynchronous reset, active-high.
- `rxd`, input, 1, serial line from the pin; asynchronous to `clk`.
- `rx_data`, output, 8, received byte; valid while `rx_valid`=1.
- `rx_valid`, output, 1, holding register contains an unconsumed byte.
- `rx_ready`, input, 1, consumer accepts the byte on a cycle with `rx_valid` && `rx_ready`.
- `frame_err`, output, 1, sticky: stop bit sampled low.
- `overrun`, output, 1, sticky: a completed byte was dropped because the holding register was full.
- `err_clr`, input, 1, synchronous clear of `frame_err`, `overrun` and `parity_err`.
- `parity_err`, output, 1, sticky parity mismatch; tied 0 when the parity feature is compiled out.
- `busy`, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; bit counter=0; baud counter=0; shift register=0.
  - Both synchroniser flops=1 (line idle).
  - `rx_data`=8'h00; `rx_valid`, `frame_err`, `overrun`, `parity_err`, `busy` all 0.
- Input synchronisation:
  - `rxd` passes through 2 flops; all logic uses the second flop (`rxd_s`).
  - This adds 2 cycles of fixed latency, so all sample points are offset by 2 cycles.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0.
  - It is reset to 0 on every state transition.
- State machine (IDLE, START, DATA, PARITY [feature only], STOP):
  - IDLE: on `rxd_s`=0 go to START, baud counter=0.
  - START: when the counter reaches `CLKS_PER_BIT/2`-1 (216), sample `rxd_s`.
    - If 1 (glitch), return to IDLE with no flags changed.
    - If 0, go to DATA, bit counter=0.
  - DATA: at each counter wrap (`CLKS_PER_BIT`-1), shift `rxd_s` into bit[7] with a right shift, so the byte is received LSB first.
    - After the 8th sample go to STOP, or to PARITY if the feature is enabled.
  - STOP: at counter wrap, sample the stop bit.
    - If 0, set `frame_err`; the byte is still delivered.
    - Then deliver the byte and go to IDLE.
    - The next start edge may be detected on the very next cycle.
- Delivery:
  - If `rx_valid`=0, or `rx_valid` && `rx_ready` in the same cycle: load `rx_data`, set `rx_valid`=1.
  - Otherwise: discard the new byte, set `overrun`=1, and leave `rx_data` unchanged.
- Handshake:
  - `rx_valid` deasserts the cycle after acceptance, unless a new byte loads in the same cycle, in which case it stays 1.
  - `rx_data` is stable while `rx_valid`=1 and not accepted.
- Sticky flags:
  - Held until `err_clr`=1.
  - If `err_clr` and a set event occur in the same cycle, set wins.
- Reset mid-frame: the partial byte is discarded; the receiver resynchronises on the next falling edge after the line is seen high.
- Break condition (line held low):
  - Gives `frame_err` plus one byte of 8'h00.
  - The FSM then stays in IDLE until the line goes high and falls again.
  - It does not retrigger on a continuous low; IDLE re-arm requires `rxd_s`=1 for at least 1 cycle.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - The frame is 8E1: the PARITY state samples the 9th bit at counter wrap.
  - If (XOR of data bits ^ sampled bit) != 0, set `parity_err`.
  - The byte is still delivered.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - `parity_err` is constant 0.

Test Plan:
- Reset, then send 8'hA5 at 115200 (434 clk/bit) -> `rx_valid`=1 with `rx_data`=8'hA5 within 3 clk after the stop-bit mid-sample; `frame_err`=0; `busy` falls at the same time.
- Low glitch of 100 clk on idle `rxd` -> no state change past START, `rx_valid` stays 0, no flags set.
- Frame 8'h3C with stop bit driven 0 -> `rx_data`=8'h3C, `frame_err`=1 and remains 1 until a single-cycle `err_clr`, then reads 0.
- Send 8'h11 then 8'h22 back-to-back with `rx_ready`=0 -> `rx_data`=8'h11, `overrun`=1. Assert `rx_ready` for 1 cycle -> `rx_valid`=0 next cycle.
- Hold `rx_ready`=1 and send 8'h00, 8'hFF, 8'h55 back-to-back -> three single-cycle `rx_valid` pulses with the correct bytes, no `overrun`.
- `UART_RX_PARITY_EN` defined: send 8'h07 with parity bit 1 -> `rx_data`=8'h07, `parity_err`=0. Send with parity bit 0 -> `parity_err`=1.
- Assert `rst` during the 4th data bit of 8'hF0 -> outputs at reset values asynchronously. A following clean frame of 8'h81 receives correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a one-entry valid/ready
// holding register and sticky framing/overrun flags.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and drives parity_err.
module uart_rx #(
  parameter int unsigned Clock = 50,      // system clock in MHz
  parameter int unsigned Baud  = 115200   // line rate in bit/s
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = (Clock * 1000000) / Baud;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            rxd_m;
  logic            rxd_s;
  // Line must be seen high in IDLE before a falling edge counts as a start bit;
  // stops a held-low line (break) from retriggering frames.
  logic            armed;

  // Two-flop synchroniser for the asynchronous line; resets to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Receive FSM, baud timing, holding register and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // Clears first so a set event later in this block wins
      if (err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      baud_cnt <= (baud_cnt == CntLast) ? '0 : baud_cnt + 1'b1;

      unique case (state)
        StIdle: begin
          baud_cnt <= '0;
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= StStart;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (baud_cnt == CntHalf) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              // Glitch: line back high at mid start bit
              state <= StIdle;
              busy  <= 1'b0;
              armed <= 1'b1;
            end else begin
              state   <= StData;
              bit_cnt <= '0;
            end
          end
        end
        StData: begin
          if (baud_cnt == CntLast) begin
            shift   <= {rxd_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (baud_cnt == CntLast) begin
            if ((^shift) ^ rxd_s) begin
              parity_err <= 1'b1;
            end
            state <= StStop;
          end
        end
`endif
        StStop: begin
          if (baud_cnt == CntLast) begin
            if (!rxd_s) begin
              frame_err <= 1'b1;
            end
            armed <= rxd_s;
            // Byte is delivered even with a bad stop bit
            if (!rx_valid || rx_ready) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
